// File: rtl/sd_spi_card_responder_if.sv
// SPI link between the host-side SD controller and the card model.
interface sd_spi_card_responder_if;
  logic spi_clk;
  logic cs;
  logic mosi;
  logic miso;
  modport master (output spi_clk, cs, mosi, input miso);
  modport slave  (input spi_clk, cs, mosi, output miso);
endinterface

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes 48-bit commands, answers R1/R3/R7, serves CMD17 from a sector store.
// Optional command CRC7 checking is enabled with SD_RESP_CRC7_CHECK_EN.
module sd_spi_card_responder #(
  parameter int          NCR_BYTES         = 1,
  parameter int          NAC_BYTES         = 2,
  parameter int          ACMD41_BUSY_COUNT = 2,
  parameter logic [31:0] OCR_VALUE         = 32'hC0FF8000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sd_spi_card_responder_if.slave spi,
  output logic                   rd_en,
  output logic [31:0]            blk_addr,
  output logic [8:0]             byte_idx,
  input  logic [7:0]             rd_data,
  output logic                   card_ready,
  output logic                   cmd_strobe,
  output logic [5:0]             cmd_index
);
  typedef enum logic [2:0] {RX_CMD, GAP, TX_RESP, TX_DGAP, TX_TOKEN, TX_DATA, TX_CRC} state_t;

  localparam logic [3:0] NCR_LAST = 4'(NCR_BYTES - 1);
  localparam logic [3:0] NAC_LAST = 4'(NAC_BYTES - 1);
  localparam logic [7:0] BUSY_CNT = 8'(ACMD41_BUSY_COUNT);

  state_t      state_q, state_d;
  logic [2:0]  sclk_s;
  logic [1:0]  cs_s, mosi_s;
  logic        cs_hi, mosi_b, rise, fall;
  logic [46:0] cmd_sr;
  logic [5:0]  cmd_cnt;
  logic [47:0] frame;
  logic        frame_done, accept, crc_bad;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  tx_byte;
  logic [39:0] resp_buf;
  logic [2:0]  resp_len;
  logic        go_data;
  logic [8:0]  dcnt;
  logic [7:0]  data_q;
  logic        rd_dly;
  logic        idle_bit, cmd55_seen;
  logic [7:0]  acmd_cnt;
  logic        miso_q;
  logic [7:0]  r1, acmd_d;
  logic [39:0] resp_d;
  logic [2:0]  len_d;
  logic        go_d, idle_d, ready_d, c55_d;
  logic        byte_done, last_byte, rd_en_d;

  assign cs_hi      = cs_s[1];
  assign mosi_b     = mosi_s[1];
  assign rise       = sclk_s[1] & ~sclk_s[2];
  assign fall       = ~sclk_s[1] & sclk_s[2];
  assign frame      = {cmd_sr, mosi_b};
  assign frame_done = (state_q == RX_CMD) && rise && (cmd_cnt == 6'd47);
  assign accept     = frame_done && frame[46] && frame[0];
  assign byte_done  = rise && (bit_cnt == 3'd7);
  assign spi.miso   = miso_q;

`ifdef SD_RESP_CRC7_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
  assign crc_bad = crc7(frame[47:8]) != frame[7:1];
`else
  logic unused_crc;
  assign unused_crc = ^frame[7:1] ^ frame[47];
  assign crc_bad    = 1'b0;
`endif

  // Command decode: response bytes (left-aligned) and the status updates to apply on accept.
  always_comb begin
    r1      = {5'b0, 1'b1, 1'b0, idle_bit};
    len_d   = 3'd1;
    go_d    = 1'b0;
    idle_d  = idle_bit;
    ready_d = card_ready;
    c55_d   = 1'b0;
    acmd_d  = acmd_cnt;
    if (crc_bad) begin
      r1    = {4'b0, 1'b1, 2'b0, idle_bit};
      c55_d = cmd55_seen;
    end else begin
      case (frame[45:40])
        6'd0: begin
          idle_d = 1'b1; ready_d = 1'b0; acmd_d = '0; r1 = 8'h01;
        end
        6'd8: begin
          r1 = {7'b0, idle_bit}; len_d = 3'd5;
        end
        6'd55: begin
          c55_d = 1'b1; r1 = {7'b0, idle_bit};
        end
        6'd41: if (cmd55_seen) begin
          if (acmd_cnt < BUSY_CNT) begin
            acmd_d = acmd_cnt + 8'd1; r1 = 8'h01;
          end else begin
            idle_d = 1'b0; ready_d = 1'b1; r1 = 8'h00;
          end
        end
        6'd58: begin
          r1 = {7'b0, idle_bit}; len_d = 3'd5;
        end
        6'd17: if (!idle_bit) begin
          r1 = 8'h00; go_d = 1'b1;
        end else begin
          r1 = 8'h05;
        end
        default: ;
      endcase
    end
    resp_d = {r1, 32'h0};
    if (!crc_bad && frame[45:40] == 6'd8)  resp_d = {r1, 24'h000001, frame[15:8]};
    if (!crc_bad && frame[45:40] == 6'd58) resp_d = {r1, OCR_VALUE};
  end

  always_comb begin
    last_byte = 1'b0;
    case (state_q)
      GAP:      last_byte = byte_cnt == NCR_LAST;
      TX_RESP:  last_byte = byte_cnt == {1'b0, resp_len - 3'd1};
      TX_DGAP:  last_byte = byte_cnt == NAC_LAST;
      TX_TOKEN: last_byte = 1'b1;
      TX_DATA:  last_byte = dcnt == 9'd511;
      TX_CRC:   last_byte = byte_cnt == 4'd1;
      default:  last_byte = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (cs_hi) state_d = RX_CMD;
    else if (state_q == RX_CMD) begin
      if (accept) state_d = GAP;
    end else if (byte_done && last_byte) begin
      case (state_q)
        GAP:      state_d = TX_RESP;
        TX_RESP:  state_d = go_data ? TX_DGAP : RX_CMD;
        TX_DGAP:  state_d = TX_TOKEN;
        TX_TOKEN: state_d = TX_DATA;
        TX_DATA:  state_d = TX_CRC;
        default:  state_d = RX_CMD;
      endcase
    end
    // Fetch the next sector byte mid-way through the byte before it; none during the last data byte.
    rd_en_d = !cs_hi && rise && (bit_cnt == 3'd3) &&
              (state_q == TX_TOKEN || (state_q == TX_DATA && dcnt != 9'd511));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RX_CMD;
    else        state_q <= state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0; cs_s <= '1; mosi_s <= '1;
      cmd_sr <= '0; cmd_cnt <= '0; bit_cnt <= '0; byte_cnt <= '0;
      tx_byte <= 8'hFF; resp_buf <= '0; resp_len <= 3'd1; go_data <= 1'b0;
      dcnt <= '0; data_q <= '0; rd_dly <= 1'b0; rd_en <= 1'b0;
      idle_bit <= 1'b1; cmd55_seen <= 1'b0; acmd_cnt <= '0; card_ready <= 1'b0;
      miso_q <= 1'b1; blk_addr <= '0; byte_idx <= '0; cmd_strobe <= 1'b0; cmd_index <= '0;
    end else begin
      sclk_s     <= {sclk_s[1:0], spi.spi_clk};
      cs_s       <= {cs_s[0], spi.cs};
      mosi_s     <= {mosi_s[0], spi.mosi};
      cmd_strobe <= 1'b0;
      rd_en      <= rd_en_d;
      rd_dly     <= rd_en;
      if (rd_dly) data_q <= rd_data;
      if (cs_hi) begin
        miso_q <= 1'b1; bit_cnt <= '0; cmd_cnt <= '0; byte_cnt <= '0;
      end else begin
        if (fall) miso_q <= (state_q == RX_CMD) ? 1'b1 : tx_byte[~bit_cnt];
        if (state_q == RX_CMD) begin
          if (rise) begin
            cmd_sr <= {cmd_sr[45:0], mosi_b};
            if (cmd_cnt == 6'd0) cmd_cnt <= {5'd0, ~mosi_b};
            else if (frame_done) cmd_cnt <= '0;
            else                 cmd_cnt <= cmd_cnt + 6'd1;
          end
          if (accept) begin
            cmd_strobe <= 1'b1;
            cmd_index  <= frame[45:40];
            tx_byte    <= 8'hFF;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            resp_buf   <= resp_d;
            resp_len   <= len_d;
            go_data    <= go_d;
            idle_bit   <= idle_d;
            card_ready <= ready_d;
            cmd55_seen <= c55_d;
            acmd_cnt   <= acmd_d;
            if (go_d) blk_addr <= frame[39:8];
          end
        end else if (rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_byte <= 8'hFF;
            if (last_byte) begin
              byte_cnt <= '0;
              case (state_q)
                GAP:      begin tx_byte <= resp_buf[39:32]; resp_buf <= resp_buf << 8; end
                TX_DGAP:  begin tx_byte <= 8'hFE; byte_idx <= '0; end
                TX_TOKEN: begin tx_byte <= data_q; dcnt <= '0; byte_idx <= 9'd1; end
                TX_DATA:  byte_idx <= '0;
                default: ;
              endcase
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              if (state_q == TX_RESP) begin
                tx_byte <= resp_buf[39:32]; resp_buf <= resp_buf << 8;
              end
              if (state_q == TX_DATA) begin
                tx_byte <= data_q; dcnt <= dcnt + 9'd1; byte_idx <= byte_idx + 9'd1;
              end
            end
          end
        end
      end
    end
  end
endmodule
